// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard for long-latency producers (loads, mul/div).
// Combinational stall/single-issue decisions from per-GPR countdowns plus HI/LO busy state.
module issue_scoreboard #(
  parameter int NREG  = 32,
  parameter int LAT_W = 2,
  parameter int NSRC  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pipe_stall,
  input  logic                   flush,
  input  logic [1:0]             iss_valid,
  input  logic [1:0]             iss_wen,
  input  logic [1:0][4:0]        iss_dst,
  input  logic [1:0][LAT_W-1:0]  iss_lat,
  input  logic [1:0]             iss_md,
  input  logic                   md_done,
  input  logic [NSRC-1:0][4:0]   src_addr,
  input  logic [1:0]             src_hilo,
  output logic                   stall_o,
  output logic                   single_o,
  output logic [NREG-1:0]        busy_o
);

  logic [NREG-1:0]            pend_q, pend_d;
  logic [NREG-1:0]            wmd_q, wmd_d;
  logic [NREG-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic                       hl_busy_q, hl_busy_d;

  logic [NSRC-1:0] src_nr;
  logic [1:0]      hilo_rd;
  logic            hilo_nr;
  logic            raw_hazard;
  logic            stall_int;
  logic            single_int;
  logic [1:0]      acc;

  // A pending register becomes usable in the cycle its registered count reads zero.
  always_comb begin
    src_nr = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_nr[i] = (src_addr[i] != '0) && pend_q[src_addr[i]] &&
                  ((cnt_q[src_addr[i]] != '0) || wmd_q[src_addr[i]]);
    end
  end

  // A second mul/div while HI/LO is busy is held off like a HI/LO read.
  always_comb begin
    hilo_rd    = src_hilo | (iss_md & {2{hl_busy_q}});
    hilo_nr    = hl_busy_q & ~md_done;
    raw_hazard = iss_wen[0] && (iss_dst[0] != '0) &&
                 ((iss_dst[0] == src_addr[3]) || (iss_dst[0] == src_addr[2])) &&
                 ((iss_lat[0] != '0) || iss_md[0]);
    stall_int  = (|src_nr[1:0]) | (hilo_rd[0] & hilo_nr);
    single_int = ~stall_int & ((|src_nr[3:2]) | (hilo_rd[1] & hilo_nr) | raw_hazard |
                               (iss_md[0] & (iss_md[1] | src_hilo[1])));
    stall_o    = ~reset & stall_int;
    single_o   = ~reset & single_int;
    acc[0]     = iss_valid[0] & ~stall_int & ~pipe_stall;
    acc[1]     = iss_valid[1] & ~stall_int & ~single_int & ~pipe_stall;
  end

  // Flush beats new issues, new issues beat countdown and md_done; slot1 wins a same-register WAW.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    wmd_d  = wmd_q;
    for (int r = 1; r < NREG; r++) begin
      if (flush) begin
        pend_d[r] = 1'b0;
        cnt_d[r]  = '0;
        wmd_d[r]  = 1'b0;
      end else if (acc[1] && iss_wen[1] && (int'(iss_dst[1]) == r)) begin
        pend_d[r] = (iss_lat[1] != '0) || iss_md[1];
        cnt_d[r]  = iss_lat[1];
        wmd_d[r]  = iss_md[1];
      end else if (acc[0] && iss_wen[0] && (int'(iss_dst[0]) == r)) begin
        pend_d[r] = (iss_lat[0] != '0) || iss_md[0];
        cnt_d[r]  = iss_lat[0];
        wmd_d[r]  = iss_md[0];
      end else begin
        if (!pipe_stall && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
          if ((cnt_q[r] == LAT_W'(1)) && !wmd_q[r]) pend_d[r] = 1'b0;
        end
        if (md_done) begin
          wmd_d[r] = 1'b0;
          if (cnt_d[r] == '0) pend_d[r] = 1'b0;
        end
      end
    end
    pend_d[0] = 1'b0;
    cnt_d[0]  = '0;
    wmd_d[0]  = 1'b0;
  end

  // HI/LO stays busy across a flush since the mul/div unit keeps running.
  always_comb begin
    hl_busy_d = hl_busy_q;
    if (!flush && (|(acc & iss_md))) hl_busy_d = 1'b1;
    else if (md_done)                hl_busy_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      cnt_q     <= '0;
      wmd_q     <= '0;
      hl_busy_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      wmd_q     <= wmd_d;
      hl_busy_q <= hl_busy_d;
    end
  end

  assign busy_o = pend_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: per-register remaining-cycle model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_issue_scoreboard;

  logic             clk = 1'b0;
  logic             reset;
  logic             pipe_stall, flush;
  logic [1:0]       iss_valid, iss_wen, iss_md, src_hilo;
  logic [1:0][4:0]  iss_dst;
  logic [1:0][1:0]  iss_lat;
  logic             md_done;
  logic [3:0][4:0]  src_addr;
  logic             stall_o, single_o;
  logic [31:0]      busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: cycles left until each register's result is bypassable, plus waiting-on-mul/div flags.
  int m_remain[32];
  bit m_wait[32];
  bit m_hl;

  issue_scoreboard #(.NREG(32), .LAT_W(2), .NSRC(4)) dut (
    .clk(clk), .reset(reset), .pipe_stall(pipe_stall), .flush(flush),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dst(iss_dst), .iss_lat(iss_lat),
    .iss_md(iss_md), .md_done(md_done), .src_addr(src_addr), .src_hilo(src_hilo),
    .stall_o(stall_o), .single_o(single_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic bit m_nr(logic [4:0] a);
    return (a != 5'd0) && ((m_remain[a] > 0) || m_wait[a]);
  endfunction

  function automatic void model_out(output bit es, output bit esg);
    bit hl_nr, rd0, rd1, raw;
    hl_nr = m_hl && !md_done;
    rd0   = src_hilo[0] || (iss_md[0] && m_hl);
    rd1   = src_hilo[1] || (iss_md[1] && m_hl);
    raw   = iss_wen[0] && (iss_dst[0] != 5'd0) &&
            ((iss_dst[0] == src_addr[2]) || (iss_dst[0] == src_addr[3])) &&
            ((iss_lat[0] != 2'd0) || iss_md[0]);
    es    = m_nr(src_addr[0]) || m_nr(src_addr[1]) || (rd0 && hl_nr);
    esg   = !es && (m_nr(src_addr[2]) || m_nr(src_addr[3]) || (rd1 && hl_nr) || raw ||
                    (iss_md[0] && (iss_md[1] || src_hilo[1])));
    if (reset) begin
      es  = 1'b0;
      esg = 1'b0;
    end
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_remain[r] > 0) || m_wait[r];
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit es, esg, a0, a1, w0, w1;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_remain[r] = 0;
        m_wait[r]   = 1'b0;
      end
      m_hl = 1'b0;
    end else begin
      model_out(es, esg);
      a0 = iss_valid[0] && !es && !pipe_stall;
      a1 = iss_valid[1] && !es && !esg && !pipe_stall;
      for (int r = 1; r < 32; r++) begin
        w1 = a1 && iss_wen[1] && (iss_dst[1] == 5'(r));
        w0 = a0 && iss_wen[0] && (iss_dst[0] == 5'(r));
        if (flush) begin
          m_remain[r] = 0;
          m_wait[r]   = 1'b0;
        end else if (w1) begin
          m_remain[r] = int'(iss_lat[1]);
          m_wait[r]   = iss_md[1];
        end else if (w0) begin
          m_remain[r] = int'(iss_lat[0]);
          m_wait[r]   = iss_md[0];
        end else begin
          if (!pipe_stall && m_remain[r] > 0) m_remain[r] = m_remain[r] - 1;
          if (md_done) m_wait[r] = 1'b0;
        end
      end
      if (!flush && ((a0 && iss_md[0]) || (a1 && iss_md[1]))) m_hl = 1'b1;
      else if (md_done) m_hl = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, outputs against the model.
  always @(negedge clk) begin
    bit es, esg;
    model_out(es, esg);
    checkOutput("model_stall", {31'd0, stall_o}, {31'd0, es});
    checkOutput("model_single", {31'd0, single_o}, {31'd0, esg});
    checkOutput("model_busy", busy_o, model_busy());
  end

  task automatic clearInputs();
    pipe_stall = 1'b0; flush = 1'b0; md_done = 1'b0;
    iss_valid = '0; iss_wen = '0; iss_md = '0; src_hilo = '0;
    iss_dst = '0; iss_lat = '0; src_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    clearInputs();
    pipe_stall = ($urandom_range(0, 4) == 0);
    flush      = ($urandom_range(0, 39) == 0);
    md_done    = m_hl && ($urandom_range(0, 3) == 0);
    iss_valid  = 2'($urandom_range(0, 3));
    iss_wen    = 2'($urandom_range(0, 3));
    src_hilo   = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
    for (int k = 0; k < 2; k++) begin
      iss_dst[k] = 5'($urandom_range(0, 7));
      iss_lat[k] = 2'($urandom_range(0, 3));
      iss_md[k]  = ($urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 4; i++) src_addr[i] = 5'($urandom_range(0, 7));
  endtask

  initial begin
    int cnt;
    clearInputs();
    reset = 1'b1;
    #3;
    checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("reset_busy", busy_o, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Load r5 lat 2, dependent slot0 source each cycle.
    tick();
    iss_valid = 2'b01; iss_wen = 2'b01; iss_dst[0] = 5'd5; iss_lat[0] = 2'd2;
    #1 checkOutput("t1_issue_stall", {31'd0, stall_o}, 32'd0);
    tick(); clearInputs(); src_addr[0] = 5'd5;
    #1 checkOutput("t1_stall_c1", {31'd0, stall_o}, 32'd1);
    checkOutput("t1_busy5_c1", {31'd0, busy_o[5]}, 32'd1);
    tick();
    #1 checkOutput("t1_stall_c2", {31'd0, stall_o}, 32'd1);
    tick();
    #1 checkOutput("t1_stall_c3", {31'd0, stall_o}, 32'd0);
    checkOutput("t1_busy5_c3", {31'd0, busy_o[5]}, 32'd0);

    // Same load with three frozen cycles.
    tick(); clearInputs();
    iss_valid = 2'b01; iss_wen = 2'b01; iss_dst[0] = 5'd5; iss_lat[0] = 2'd2;
    tick(); clearInputs(); src_addr[0] = 5'd5;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      pipe_stall = (i < 3);
      #1 if (stall_o) cnt++;
      tick();
    end
    checkOutput("t2_stall_cycles", cnt, 32'd5);

    // Slot0 load r7 feeding slot1 in the same bundle.
    clearInputs();
    iss_valid = 2'b11; iss_wen = 2'b01; iss_dst[0] = 5'd7; iss_lat[0] = 2'd1; src_addr[2] = 5'd7;
    #1 checkOutput("t3_single", {31'd0, single_o}, 32'd1);
    checkOutput("t3_stall", {31'd0, stall_o}, 32'd0);
    tick(); clearInputs(); iss_valid = 2'b01; src_addr[0] = 5'd7;
    #1 checkOutput("t3_replay_stall", {31'd0, stall_o}, 32'd1);
    tick();
    #1 checkOutput("t3_replay_go", {31'd0, stall_o}, 32'd0);

    // Divide to r9, then mfhi until md_done.
    tick(); clearInputs();
    iss_valid = 2'b01; iss_wen = 2'b01; iss_dst[0] = 5'd9; iss_md = 2'b01;
    tick(); clearInputs(); iss_valid = 2'b01; src_hilo = 2'b01;
    #1 checkOutput("t4_mfhi_c1", {31'd0, stall_o}, 32'd1);
    tick();
    #1 checkOutput("t4_mfhi_c2", {31'd0, stall_o}, 32'd1);
    checkOutput("t4_busy9", {31'd0, busy_o[9]}, 32'd1);
    tick(); md_done = 1'b1;
    #1 checkOutput("t4_done_stall", {31'd0, stall_o}, 32'd0);
    tick(); md_done = 1'b0; iss_valid = 2'b00;
    #1 checkOutput("t4_busy9_clr", {31'd0, busy_o[9]}, 32'd0);

    // Load r3 lat 3 then flush.
    tick(); clearInputs();
    iss_valid = 2'b01; iss_wen = 2'b01; iss_dst[0] = 5'd3; iss_lat[0] = 2'd3;
    tick(); clearInputs(); flush = 1'b1; src_addr[0] = 5'd3;
    #1 checkOutput("t5_busy_pre", busy_o, 32'h0000_0008);
    tick(); flush = 1'b0;
    #1 checkOutput("t5_busy_post", busy_o, 32'd0);
    checkOutput("t5_stall", {31'd0, stall_o}, 32'd0);

    // Both slots write r4; r0 never tracked.
    tick(); clearInputs();
    iss_valid = 2'b11; iss_wen = 2'b11; iss_dst[0] = 5'd4; iss_lat[0] = 2'd2; iss_dst[1] = 5'd4;
    tick(); clearInputs(); src_addr[0] = 5'd4;
    #1 checkOutput("t6_busy4", {31'd0, busy_o[4]}, 32'd0);
    checkOutput("t6_stall", {31'd0, stall_o}, 32'd0);
    tick(); clearInputs(); iss_valid = 2'b01; iss_wen = 2'b01; iss_lat[0] = 2'd3;
    tick(); clearInputs();
    #1 checkOutput("t6_r0_busy", busy_o, 32'd0);
    checkOutput("t6_r0_stall", {31'd0, stall_o}, 32'd0);

    // Asynchronous reset in the middle of a countdown.
    clearInputs(); iss_valid = 2'b01; iss_wen = 2'b01; iss_dst[0] = 5'd6; iss_lat[0] = 2'd3;
    tick(); clearInputs(); src_addr[0] = 5'd6;
    #1 checkOutput("rst_pre_stall", {31'd0, stall_o}, 32'd1);
    #1 reset = 1'b1;
    #1 checkOutput("rst_mid_busy", busy_o, 32'd0);
    checkOutput("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    tick(); reset = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      tick();
      applyStimulus();
    end
    tick(); clearInputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
